uart_io_ctrl: RTL and testbench

Sequences the execution core's UART word-level requests (uart_wenable/uart_wdone, uart_renable/uart_rdone) onto a byte-serial UART PHY. It buffers outbound bytes in a TX FIFO and inbound bytes in an RX FIFO, so the core sees one-cycle completion whenever buffer space or data is available. It sits between the exec unit and the uart_tx/uart_rx PHYs, and owns all flow control between them.

---
 rtl/uart_ctrl_pkg.sv | 15 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_io_ctrl.sv | 157 +++++++++++++++
 tb/tb_uart_io_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared constants and types for the UART I/O controller.
package uart_ctrl_pkg;

    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned WORD_W       = 32;
    localparam int unsigned TX_DEPTH_DEF = 16;
    localparam int unsigned RX_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LAUNCH,
        TX_BUSY
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head; push while full is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_next_c;
    logic             push_eff_c;
    logic             pop_eff_c;

    assign full          = (count == CW'(DEPTH));
    assign empty         = (count == '0);
    assign pop_eff_c     = pop && !empty;
    assign push_eff_c    = push && (!full || pop_eff_c);
    assign rd_ptr_next_c = pop_eff_c ? rd_ptr + AW'(1) : rd_ptr;

    always_ff @(posedge clk) begin
        if (push_eff_c) begin
            mem[wr_ptr] <= din;
        end
    end

    // Head tracks the slot rd_ptr will point at next; bypass din when it lands there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push_eff_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_next_c;
            case ({push_eff_c, pop_eff_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_eff_c && (wr_ptr == rd_ptr_next_c)) begin
                head <= din;
            end else begin
                head <= mem[rd_ptr_next_c];
            end
        end
    end

endmodule

// File: rtl/uart_io_ctrl.sv
// Bridges exec-unit word requests to a byte-serial UART PHY through TX/RX FIFOs,
// with one pending request per direction when the buffers cannot serve at once.
module uart_io_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned TX_DEPTH = TX_DEPTH_DEF,
    parameter int unsigned RX_DEPTH = RX_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_wenable,
    input  logic [WORD_W-1:0] uart_wd,
    output logic              uart_wdone,
    input  logic              uart_renable,
    output logic              uart_rdone,
    output logic [WORD_W-1:0] uart_rd,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_overflow
);

    tx_state_t                 tx_state;
    logic                      pend_wr;
    logic [BYTE_W-1:0]         pend_byte;
    logic                      pend_rd;

    logic                      wr_new_c;
    logic                      rd_new_c;
    logic                      tx_push_c;
    logic                      tx_pop_c;
    logic [BYTE_W-1:0]         tx_din_c;
    logic                      rx_pop_c;

    logic [BYTE_W-1:0]         tx_head;
    logic                      tx_full;
    logic                      tx_empty;
    logic [$clog2(TX_DEPTH):0] tx_count;
    logic [BYTE_W-1:0]         rx_head;
    logic                      rx_full;
    logic                      rx_empty;
    logic [$clog2(RX_DEPTH):0] rx_count;
    logic                      unused_bits_c;

    // Only the low byte of a write word travels; occupancy counts are informational.
    assign unused_bits_c = ^{uart_wd[WORD_W-1:BYTE_W], tx_count, rx_count};

    // Requests arriving while the same direction is pending are dropped.
    assign wr_new_c  = uart_wenable && !pend_wr;
    assign rd_new_c  = uart_renable && !pend_rd;
    assign tx_pop_c  = (tx_state == TX_IDLE) && !tx_empty && !tx_busy;
    assign tx_push_c = (wr_new_c && !tx_full) || (pend_wr && (!tx_full || tx_pop_c));
    assign tx_din_c  = pend_wr ? pend_byte : uart_wd[BYTE_W-1:0];
    assign rx_pop_c  = (rd_new_c || pend_rd) && !rx_empty;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push_c),
        .pop   (tx_pop_c),
        .din   (tx_din_c),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .pop   (rx_pop_c),
        .din   (rx_data),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // Exec-side handshakes, pending flags and overflow tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_wdone  <= 1'b0;
            uart_rdone  <= 1'b0;
            uart_rd     <= '0;
            pend_wr     <= 1'b0;
            pend_byte   <= '0;
            pend_rd     <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            uart_wdone <= tx_push_c;
            uart_rdone <= rx_pop_c;

            if (wr_new_c && tx_full) begin
                pend_wr   <= 1'b1;
                pend_byte <= uart_wd[BYTE_W-1:0];
            end else if (pend_wr && tx_push_c) begin
                pend_wr <= 1'b0;
            end

            if (rx_pop_c) begin
                uart_rd <= WORD_W'(rx_head);
            end

            if (rd_new_c && rx_empty) begin
                pend_rd <= 1'b1;
            end else if (rx_pop_c) begin
                pend_rd <= 1'b0;
            end

            if (rx_valid && rx_full && !rx_pop_c) begin
                rx_overflow <= 1'b1;
            end
        end
    end

    // TX launcher: one byte per PHY transfer, tx_busy is not trusted in LAUNCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_data  <= '0;
            tx_start <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop_c) begin
                        tx_data  <= tx_head;
                        tx_start <= 1'b1;
                        tx_state <= TX_LAUNCH;
                    end
                end
                TX_LAUNCH: begin
                    tx_start <= 1'b0;
                    tx_state <= TX_BUSY;
                end
                TX_BUSY: begin
                    if (!tx_busy) begin
                        tx_state <= TX_IDLE;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed self-checking bench for uart_io_ctrl.
module tb_uart_io_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_wenable;
    logic [31:0] uart_wd;
    logic        uart_wdone;
    logic        uart_renable;
    logic        uart_rdone;
    logic [31:0] uart_rd;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_overflow;

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    int         n_start = 0;
    int         n_wdone = 0;
    int         n_rdone = 0;
    int         n_double = 0;
    logic       prev_start = 1'b0;
    logic [7:0] phy_q[$];
    int         start_cyc_q[$];

    uart_io_ctrl #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_wenable (uart_wenable),
        .uart_wd      (uart_wd),
        .uart_wdone   (uart_wdone),
        .uart_renable (uart_renable),
        .uart_rdone   (uart_rdone),
        .uart_rd      (uart_rd),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_overflow  (rx_overflow)
    );

    always #5 clk = ~clk;

    // PHY-side observer
    always @(negedge clk) begin
        cyc++;
        if (tx_start) begin
            phy_q.push_back(tx_data);
            start_cyc_q.push_back(cyc);
            n_start++;
        end
        if (tx_start && prev_start) n_double++;
        prev_start = tx_start;
        if (uart_wdone) n_wdone++;
        if (uart_rdone) n_rdone++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        uart_wenable = 1'b0; uart_wd = '0; uart_renable = 1'b0;
        tx_busy = 1'b0; rx_data = '0; rx_valid = 1'b0;
        #3;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %0h exp 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %0h exp 0", tx_data); end
        checks++; if (uart_wdone !== 1'b0) begin errors++; $display("FAIL reset_wdone got %0h exp 0", uart_wdone); end
        checks++; if (uart_rdone !== 1'b0) begin errors++; $display("FAIL reset_rdone got %0h exp 0", uart_rdone); end
        checks++; if (uart_rd !== 32'h0) begin errors++; $display("FAIL reset_rd got %0h exp 0", uart_rd); end
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0h exp 0", rx_overflow); end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        tx_busy = 1'b0;
        uart_wenable = 1'b1; uart_wd = 32'h1234_5641;
        tick();
        uart_wenable = 1'b0;
        checks++; if (uart_wdone !== 1'b1) begin errors++; $display("FAIL sw_wdone got %0h exp 1", uart_wdone); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL sw_start_early got %0h exp 0", tx_start); end
        tick();
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL sw_start got %0h exp 1", tx_start); end
        checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL sw_tx_data got %0h exp 41", tx_data); end
        checks++; if (uart_wdone !== 1'b0) begin errors++; $display("FAIL sw_wdone_pulse got %0h exp 0", uart_wdone); end
        tick();
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL sw_start_width got %0h exp 0", tx_start); end
        tick(); tick(); tick();
    endtask

    task automatic test_fill_tx();
        int base_q;
        int base_w;
        int base_d;
        int n;
        base_q = phy_q.size();
        base_d = n_double;
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            uart_wenable = 1'b1; uart_wd = 32'(i);
            tick();
            uart_wenable = 1'b0;
            checks++; if (uart_wdone !== 1'b1) begin errors++; $display("FAIL fill_wdone_%0d got %0h exp 1", i, uart_wdone); end
            tick();
        end
        uart_wenable = 1'b1; uart_wd = 32'd16;
        tick();
        uart_wenable = 1'b0;
        checks++; if (uart_wdone !== 1'b0) begin errors++; $display("FAIL fill_full_wdone got %0h exp 0", uart_wdone); end
        // A second write while pending must be ignored.
        uart_wenable = 1'b1; uart_wd = 32'hEE;
        tick();
        uart_wenable = 1'b0;
        base_w = n_wdone;
        tick(); tick(); tick();
        checks++; if (n_wdone != base_w || uart_wdone !== 1'b0) begin errors++; $display("FAIL fill_pending_hold got %0d exp 0 wdones", n_wdone - base_w); end
        tx_busy = 1'b0;
        tick();
        checks++; if (uart_wdone !== 1'b1) begin errors++; $display("FAIL fill_pending_wdone got %0h exp 1", uart_wdone); end
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL fill_first_start got %0h exp 1", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL fill_first_byte got %0h exp 0", tx_data); end
        for (int k = 0; k < 300 && (phy_q.size() - base_q) < 17; k++) tick();
        tick(); tick(); tick(); tick(); tick();
        n = phy_q.size() - base_q;
        checks++; if (n != 17) begin errors++; $display("FAIL fill_byte_count got %0d exp 17", n); end
        for (int i = 0; i < 17 && i < n; i++) begin
            checks++; if (phy_q[base_q + i] !== 8'(i)) begin errors++; $display("FAIL fill_order_%0d got %0h exp %0h", i, phy_q[base_q + i], 8'(i)); end
        end
        for (int i = 1; i < n; i++) begin
            checks++; if (start_cyc_q[base_q + i] - start_cyc_q[base_q + i - 1] < 3) begin errors++; $display("FAIL fill_spacing_%0d got %0d exp >=3", i, start_cyc_q[base_q + i] - start_cyc_q[base_q + i - 1]); end
        end
        checks++; if (n_double != base_d) begin errors++; $display("FAIL fill_start_width got %0d exp 0 wide pulses", n_double - base_d); end
    endtask

    task automatic test_read_present();
        rx_valid = 1'b1; rx_data = 8'hA5;
        tick();
        rx_valid = 1'b0;
        checks++; if (uart_rdone !== 1'b0) begin errors++; $display("FAIL rp_no_rdone got %0h exp 0", uart_rdone); end
        tick();
        uart_renable = 1'b1;
        tick();
        uart_renable = 1'b0;
        checks++; if (uart_rdone !== 1'b1) begin errors++; $display("FAIL rp_rdone got %0h exp 1", uart_rdone); end
        checks++; if (uart_rd !== 32'h0000_00A5) begin errors++; $display("FAIL rp_rd got %0h exp a5", uart_rd); end
        tick();
        checks++; if (uart_rdone !== 1'b0) begin errors++; $display("FAIL rp_rdone_pulse got %0h exp 0", uart_rdone); end
        checks++; if (uart_rd !== 32'h0000_00A5) begin errors++; $display("FAIL rp_rd_hold got %0h exp a5", uart_rd); end
    endtask

    task automatic test_pending_read();
        int base_r;
        base_r = n_rdone;
        uart_renable = 1'b1;
        tick();
        uart_renable = 1'b0;
        checks++; if (uart_rdone !== 1'b0) begin errors++; $display("FAIL pr_empty_rdone got %0h exp 0", uart_rdone); end
        uart_renable = 1'b1;
        tick();
        uart_renable = 1'b0;
        tick();
        checks++; if (uart_rdone !== 1'b0) begin errors++; $display("FAIL pr_wait_rdone got %0h exp 0", uart_rdone); end
        rx_valid = 1'b1; rx_data = 8'h3C;
        tick();
        rx_valid = 1'b0;
        checks++; if (uart_rdone !== 1'b0) begin errors++; $display("FAIL pr_r1_rdone got %0h exp 0", uart_rdone); end
        tick();
        checks++; if (uart_rdone !== 1'b1) begin errors++; $display("FAIL pr_r2_rdone got %0h exp 1", uart_rdone); end
        checks++; if (uart_rd !== 32'h0000_003C) begin errors++; $display("FAIL pr_rd got %0h exp 3c", uart_rd); end
        rx_valid = 1'b1; rx_data = 8'h77;
        tick();
        rx_valid = 1'b0;
        tick(); tick();
        checks++; if (n_rdone - base_r != 1) begin errors++; $display("FAIL pr_rdone_count got %0d exp 1", n_rdone - base_r); end
        // Drain the extra byte so RX is empty again.
        uart_renable = 1'b1;
        tick();
        uart_renable = 1'b0;
        checks++; if (uart_rd !== 32'h0000_0077) begin errors++; $display("FAIL pr_drain_rd got %0h exp 77", uart_rd); end
        tick();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_b;
        for (int i = 0; i < 16; i++) begin
            rx_valid = 1'b1; rx_data = 8'h10 + 8'(i);
            tick();
        end
        rx_valid = 1'b0;
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL ov_full_no_flag got %0h exp 0", rx_overflow); end
        uart_renable = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
        tick();
        uart_renable = 1'b0; rx_valid = 1'b0;
        checks++; if (uart_rdone !== 1'b1) begin errors++; $display("FAIL ov_swap_rdone got %0h exp 1", uart_rdone); end
        checks++; if (uart_rd !== 32'h10) begin errors++; $display("FAIL ov_swap_rd got %0h exp 10", uart_rd); end
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL ov_swap_flag got %0h exp 0", rx_overflow); end
        rx_valid = 1'b1; rx_data = 8'h99;
        tick();
        rx_valid = 1'b0;
        checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL ov_flag got %0h exp 1", rx_overflow); end
        tick();
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 15) ? 8'h11 + 8'(i) : 8'hEE;
            uart_renable = 1'b1;
            tick();
            uart_renable = 1'b0;
            checks++; if (uart_rdone !== 1'b1 || uart_rd !== 32'(exp_b)) begin errors++; $display("FAIL ov_read_%0d got rdone=%0h rd=%0h exp rdone=1 rd=%0h", i, uart_rdone, uart_rd, exp_b); end
            tick();
        end
        uart_renable = 1'b1;
        tick();
        uart_renable = 1'b0;
        checks++; if (uart_rdone !== 1'b0) begin errors++; $display("FAIL ov_dropped_byte got rdone=%0h rd=%0h exp no rdone", uart_rdone, uart_rd); end
        checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL ov_sticky got %0h exp 1", rx_overflow); end
        tick();
    endtask

    task automatic test_reset_mid();
        int base_s;
        int base_w;
        int base_r;
        // Serves the read left pending by the previous test.
        rx_valid = 1'b1; rx_data = 8'h5A;
        tick();
        rx_valid = 1'b0;
        tick();
        checks++; if (uart_rdone !== 1'b1 || uart_rd !== 32'h5A) begin errors++; $display("FAIL rm_pre_read got rdone=%0h rd=%0h exp rdone=1 rd=5a", uart_rdone, uart_rd); end
        uart_renable = 1'b1;
        tick();
        uart_renable = 1'b0;
        base_s = n_start;
        tx_busy = 1'b0;
        uart_wenable = 1'b1; uart_wd = 32'hA0;
        tick();
        uart_wenable = 1'b0;
        tick();
        tx_busy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            uart_wenable = 1'b1; uart_wd = 32'hA0 + 32'(i);
            tick();
            uart_wenable = 1'b0;
            tick();
        end
        checks++; if (n_start - base_s != 1 || tx_data !== 8'hA0) begin errors++; $display("FAIL rm_one_launch got starts=%0d data=%0h exp starts=1 data=a0", n_start - base_s, tx_data); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (tx_data !== 8'h00 || tx_start !== 1'b0) begin errors++; $display("FAIL rm_tx_outputs got data=%0h start=%0h exp 0", tx_data, tx_start); end
        checks++; if (uart_rd !== 32'h0 || uart_rdone !== 1'b0 || uart_wdone !== 1'b0) begin errors++; $display("FAIL rm_exec_outputs got rd=%0h rdone=%0h wdone=%0h exp 0", uart_rd, uart_rdone, uart_wdone); end
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL rm_overflow got %0h exp 0", rx_overflow); end
        base_s = n_start; base_w = n_wdone; base_r = n_rdone;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        tx_busy = 1'b0;
        for (int k = 0; k < 30; k++) tick();
        checks++; if (n_start != base_s) begin errors++; $display("FAIL rm_no_start got %0d exp 0", n_start - base_s); end
        checks++; if (n_wdone != base_w || n_rdone != base_r) begin errors++; $display("FAIL rm_no_done got wdone=%0d rdone=%0d exp 0", n_wdone - base_w, n_rdone - base_r); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill_tx();
        test_read_present();
        test_pending_read();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
